// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the execute-stage ALU.
// Resolves MEM/WB operand forwarding and inserts a bubble on load-use hazards.
module ex_operand_stage #(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  input  logic [3:0]   id_alu_ctrl,
  input  logic [A-1:0] id_rs1,
  input  logic [A-1:0] id_rs2,
  input  logic [A-1:0] id_rd,
  input  logic [N-1:0] id_rs1_data,
  input  logic [N-1:0] id_rs2_data,
  input  logic [N-1:0] id_imm,
  input  logic         id_use_imm,
  input  logic         id_reg_write,
  input  logic         id_mem_read,
  input  logic         id_mem_write,
  input  logic         stall,
  input  logic         flush,
  input  logic [A-1:0] mem_rd,
  input  logic         mem_reg_write,
  input  logic [N-1:0] mem_result,
  input  logic [A-1:0] wb_rd,
  input  logic         wb_reg_write,
  input  logic [N-1:0] wb_data,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  output logic         ex_valid,
  output logic [A-1:0] ex_rd,
  output logic         ex_reg_write,
  output logic         ex_mem_read,
  output logic         ex_mem_write,
  output logic [N-1:0] ex_store_data,
  output logic         hazard_stall
);

  logic [3:0]   ctrl_q;
  logic [A-1:0] rs1_q, rs2_q;
  logic [N-1:0] rs1_data_q, rs2_data_q, imm_q;
  logic         use_imm_q;
  logic [N-1:0] fwd1, fwd2;
  logic         match1, match2;

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    fwd1 = rs1_data_q;
    if (mem_reg_write && mem_rd == rs1_q)
      fwd1 = mem_result;
    else if (wb_reg_write && wb_rd == rs1_q)
      fwd1 = wb_data;

    fwd2 = rs2_data_q;
    if (mem_reg_write && mem_rd == rs2_q)
      fwd2 = mem_result;
    else if (wb_reg_write && wb_rd == rs2_q)
      fwd2 = wb_data;
  end

  // A store still needs rs2 even when b comes from the immediate.
  assign match1       = (id_rs1 == ex_rd);
  assign match2       = (id_rs2 == ex_rd) && (!id_use_imm || id_mem_write);
  assign hazard_stall = id_valid && ex_valid && ex_mem_read && !flush && (match1 || match2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ctrl_q       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
    end else if (stall && !flush) begin
      // Refresh operands so a producer retiring during the hold is not lost.
      rs1_data_q <= fwd1;
      rs2_data_q <= fwd2;
    end else if (flush || hazard_stall || !id_valid) begin
      ex_valid     <= 1'b0;
      ctrl_q       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      use_imm_q    <= 1'b0;
    end else begin
      ex_valid     <= 1'b1;
      ctrl_q       <= id_alu_ctrl;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      rs1_q        <= id_rs1;
      rs2_q        <= id_rs2;
      rs1_data_q   <= id_rs1_data;
      rs2_data_q   <= id_rs2_data;
      imm_q        <= id_imm;
      use_imm_q    <= id_use_imm;
    end
  end

  assign alu_a         = ex_valid ? fwd1 : '0;
  assign alu_b         = !ex_valid ? '0 : (use_imm_q ? imm_q : fwd2);
  assign ex_store_data = ex_valid ? fwd2 : '0;
  assign alu_ctrl      = ex_valid ? ctrl_q : 4'b0000;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline boundary that sits directly upstream of the execute-stage ALU.
- Registers decoded instruction fields and resolves operand forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts a bubble.
- Drives the ALU operand buses `a` and `b` and the 4-bit ALU control.

Parameters:
- N, 8, datapath width; matches ALU N.
- A, 4, register-index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  decode slot holds a real instruction
- id_alu_ctrl  in  4  ALU op code (0000 add, 0001 sub, 0010 mul, 0011 or, 0100 mod, 0101 and, 0110 copy imm, 1000 div)
- id_rs1, id_rs2, id_rd  in  A  source/destination register indices
- id_rs1_data, id_rs2_data  in  N  register-file read data
- id_imm  in  N  sign-extended immediate
- id_use_imm  in  1  operand b = immediate instead of rs2
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- stall  in  1  downstream hold request
- flush  in  1  kill request (branch taken)
- mem_rd  in  A  MEM-stage destination
- mem_reg_write  in  1  MEM-stage writes a register
- mem_result  in  N  MEM-stage value; valid for loads as well
- wb_rd  in  A  WB-stage destination
- wb_reg_write  in  1  WB-stage writes a register
- wb_data  in  N  WB-stage value
- alu_a, alu_b  out  N  ALU operands
- alu_ctrl  out  4  ALU op
- ex_valid  out  1  EX slot valid
- ex_rd  out  A  EX destination
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  registered control bits
- ex_store_data  out  N  forwarded rs2 value, used by stores
- hazard_stall  out  1  upstream must hold decode this cycle

Behaviour:
- Reset (async, immediate on rst high): every EX register clears to 0.
  - ex_valid=0, alu_ctrl=0000, ex_rd=0, all control bits 0, stored operand data 0.
  - Hence alu_a=alu_b=ex_store_data=0 and hazard_stall=0.
  - A reset mid-operation discards the held instruction; no partial state survives.
- Latency: an instruction accepted at edge k appears on the EX outputs after edge k; one cycle from ID to EX.
- Per-edge update priority (highest first):
  - flush: load a bubble (ex_valid=0, all control bits 0). Flush beats stall and hazard.
  - stall: hold all fields. Stored rs1/rs2 data is replaced with the current forwarded values (operand refresh), so a producer that retires during the hold is not lost.
  - hazard_stall: load a bubble; decode is held upstream.
  - otherwise: capture the id_* fields. An ID slot with id_valid=0 captures as a bubble.
- Forwarding (combinational from EX registers; applied only when ex_valid=1):
  - For each source: if mem_reg_write and mem_rd==rs, use mem_result.
  - Else if wb_reg_write and wb_rd==rs, use wb_data.
  - Else use the stored register-file data.
  - MEM has priority over WB. Register index 0 is an ordinary register and is forwarded like any other.
- Operand outputs:
  - alu_a = forwarded rs1.
  - alu_b = stored imm when use_imm=1, else forwarded rs2.
  - ex_store_data = forwarded rs2 always.
  - When ex_valid=0, alu_a, alu_b and ex_store_data are 0 and alu_ctrl=0000.
- hazard_stall (combinational) = id_valid & ex_valid & ex_mem_read & !flush & (match1 | match2).
  - match1 = id_rs1==ex_rd.
  - match2 = (id_rs2==ex_rd) & (!id_use_imm | id_mem_write).
  - Exactly one bubble resolves it; forwarding from MEM covers the rest.
- Simultaneous stall and hazard: stall wins (hold). hazard_stall remains asserted while the condition holds.
- No arithmetic in this block; widths pass through unchanged.

Test Plan:
- rst pulsed mid-cycle with a valid instruction held -> outputs 0 immediately, ex_valid=0; first instruction after release appears one cycle after capture.
- EX add r3=r1+r2 (rf r1=5, r2=7); mem_rd=1, mem_reg_write=1, mem_result=20; wb_rd=1, wb_data=9 -> alu_a=20 (MEM priority), alu_b=7, alu_ctrl=0000.
- Load r4 in EX, decode sub r5=r4-r1 -> hazard_stall=1 for one cycle, next EX is a bubble; load then in MEM with mem_result=0x2A -> alu_a=0x2A.
- stall held 3 cycles while producer of r1 (value 0x11) passes WB -> after stall drops, alu_a still 0x11 (operand refresh).
- flush and stall both high with a valid EX instruction -> next cycle ex_valid=0, ex_reg_write=0, alu_a=alu_b=0.
- id_use_imm=1, id_imm=0xFE, alu op 0110, rs2 matching a load in EX (not a store) -> hazard_stall=0, alu_b=0xFE.
